// File: rtl/dbus_demux3_pkg.sv
// Shared definitions for the data-bus demultiplexer slice.
//   state_e      : demux FSM states (IDLE / WAIT / RESP, 2-bit encoding)
//   TGT_*        : target indices (RAM = 0, IO = 1, TIMER = 2)
//   DEF_BASE*/DEF_MASK* : default address map
//   hit_to_idx() : priority-resolved hit vector -> target index
package dbus_demux3_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int unsigned N_TGT = 3;

  localparam logic [1:0] TGT_RAM   = 2'd0;
  localparam logic [1:0] TGT_IO    = 2'd1;
  localparam logic [1:0] TGT_TIMER = 2'd2;

  localparam logic [31:0] DEF_BASE0 = 32'h0000_0000;
  localparam logic [31:0] DEF_MASK0 = 32'hFFFF_0000;
  localparam logic [31:0] DEF_BASE1 = 32'h1000_0000;
  localparam logic [31:0] DEF_MASK1 = 32'hFFFF_F000;
  localparam logic [31:0] DEF_BASE2 = 32'h1000_1000;
  localparam logic [31:0] DEF_MASK2 = 32'hFFFF_FF00;

  function automatic logic [1:0] hit_to_idx(input logic [N_TGT-1:0] hit);
    if (hit[0])      return TGT_RAM;
    else if (hit[1]) return TGT_IO;
    else             return TGT_TIMER;
  endfunction

endpackage

// File: rtl/dbus_demux3_if.sv
// Bus bundle between the CPU data-bus initiator, the demux and its three targets.
//   m_* : initiator request/response channel
//   s_* : shared target request payload, per-target valid/ready/response
// Modports:
//   master : the environment (initiator + targets) driving the demux
//   slave  : the demux itself
interface dbus_demux3_if
  import dbus_demux3_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                    m_req_valid;
  logic                    m_req_ready;
  logic [ADDR_W-1:0]       m_addr;
  logic                    m_we;
  logic [DATA_W-1:0]       m_wdata;
  logic [DATA_W/8-1:0]     m_be;
  logic                    m_rsp_valid;
  logic [DATA_W-1:0]       m_rdata;
  logic                    m_rsp_err;

  logic [N_TGT-1:0]        s_req_valid;
  logic [N_TGT-1:0]        s_req_ready;
  logic [ADDR_W-1:0]       s_addr;
  logic                    s_we;
  logic [DATA_W-1:0]       s_wdata;
  logic [DATA_W/8-1:0]     s_be;
  logic [N_TGT-1:0]        s_rsp_valid;
  logic [N_TGT*DATA_W-1:0] s_rdata;

  modport master (
    output m_req_valid, m_addr, m_we, m_wdata, m_be,
    input  m_req_ready, m_rsp_valid, m_rdata, m_rsp_err,
    input  s_req_valid, s_addr, s_we, s_wdata, s_be,
    output s_req_ready, s_rsp_valid, s_rdata
  );

  modport slave (
    input  m_req_valid, m_addr, m_we, m_wdata, m_be,
    output m_req_ready, m_rsp_valid, m_rdata, m_rsp_err,
    output s_req_valid, s_addr, s_we, s_wdata, s_be,
    input  s_req_ready, s_rsp_valid, s_rdata
  );

endinterface

// File: rtl/dbus_demux3_addr_decode.sv
// Combinational address decoder for dbus_demux3.
//   addr_i : byte address from the initiator
//   hit_o  : priority-resolved one-hot hit vector (target 0 > 1 > 2), zero on miss
//   miss_o : no region matched
module dbus_addr_decode
  import dbus_demux3_pkg::*;
#(
  parameter int unsigned       ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE0  = ADDR_W'(DEF_BASE0),
  parameter logic [ADDR_W-1:0] MASK0  = ADDR_W'(DEF_MASK0),
  parameter logic [ADDR_W-1:0] BASE1  = ADDR_W'(DEF_BASE1),
  parameter logic [ADDR_W-1:0] MASK1  = ADDR_W'(DEF_MASK1),
  parameter logic [ADDR_W-1:0] BASE2  = ADDR_W'(DEF_BASE2),
  parameter logic [ADDR_W-1:0] MASK2  = ADDR_W'(DEF_MASK2)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [N_TGT-1:0]  hit_o,
  output logic              miss_o
);

  logic [N_TGT-1:0] raw;

  always_comb begin
    raw[0] = ((addr_i & MASK0) == BASE0);
    raw[1] = ((addr_i & MASK1) == BASE1);
    raw[2] = ((addr_i & MASK2) == BASE2);

    // Overlapping regions resolve to the lowest index.
    hit_o = '0;
    if (raw[0])      hit_o[0] = 1'b1;
    else if (raw[1]) hit_o[1] = 1'b1;
    else if (raw[2]) hit_o[2] = 1'b1;

    miss_o = ~|raw;
  end

endmodule

// File: rtl/dbus_demux3.sv
// 1-to-3 data-bus demultiplexer: routes the CPU MEM-stage initiator to
// data RAM (0), IO (1) or timer (2), tracks one outstanding transaction and
// returns the selected target's response. Unmapped addresses get an error.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : dbus_demux3_if.slave (m_* initiator side, s_* target side)
// Optional watchdog: define DBUS_TIMEOUT_EN to end a WAIT with an error
// response after TIMEOUT cycles without a target response.
module dbus_demux3
  import dbus_demux3_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 32,
  parameter int unsigned       DATA_W  = 32,
  parameter logic [ADDR_W-1:0] BASE0   = ADDR_W'(DEF_BASE0),
  parameter logic [ADDR_W-1:0] MASK0   = ADDR_W'(DEF_MASK0),
  parameter logic [ADDR_W-1:0] BASE1   = ADDR_W'(DEF_BASE1),
  parameter logic [ADDR_W-1:0] MASK1   = ADDR_W'(DEF_MASK1),
  parameter logic [ADDR_W-1:0] BASE2   = ADDR_W'(DEF_BASE2),
  parameter logic [ADDR_W-1:0] MASK2   = ADDR_W'(DEF_MASK2),
  parameter int unsigned       TIMEOUT = 255
) (
  input logic          clk,
  input logic          reset,
  dbus_demux3_if.slave bus
);

  state_e              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic                we_q, we_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [N_TGT-1:0]    hit;
  logic                miss;
  logic                req_ready;
  logic [N_TGT-1:0]    req_valid;
  logic                rsp_hit;
  logic [DATA_W-1:0]   rsp_data;

`ifdef DBUS_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WD_W-1:0]     wd_q, wd_d;
`else
  // Keeps the parameter referenced when the watchdog is compiled out.
  logic                unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  dbus_addr_decode #(
    .ADDR_W (ADDR_W),
    .BASE0  (BASE0),
    .MASK0  (MASK0),
    .BASE1  (BASE1),
    .MASK1  (MASK1),
    .BASE2  (BASE2),
    .MASK2  (MASK2)
  ) u_decode (
    .addr_i (bus.m_addr),
    .hit_o  (hit),
    .miss_o (miss)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_valid = '0;
    req_ready = 1'b0;
`ifdef DBUS_TIMEOUT_EN
    wd_d      = wd_q;
`endif

    rsp_hit  = 1'b0;
    rsp_data = '0;
    for (int unsigned i = 0; i < N_TGT; i++) begin
      if (sel_q == 2'(i)) begin
        rsp_hit  = bus.s_rsp_valid[i];
        rsp_data = bus.s_rdata[i*DATA_W +: DATA_W];
      end
    end

    case (state_q)
      S_IDLE: begin
        req_valid = {N_TGT{bus.m_req_valid}} & hit;
        // Misses are swallowed immediately; hits wait on the chosen target.
        req_ready = miss ? 1'b1 : |(hit & bus.s_req_ready);
        if (bus.m_req_valid && req_ready) begin
          if (miss) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_RESP;
          end else begin
            sel_d   = hit_to_idx(hit);
            we_d    = bus.m_we;
            state_d = S_WAIT;
`ifdef DBUS_TIMEOUT_EN
            wd_d    = '0;
`endif
          end
        end
      end
      S_WAIT: begin
        if (rsp_hit) begin
          rdata_d = we_q ? '0 : rsp_data;
          err_d   = 1'b0;
          state_d = S_RESP;
        end
`ifdef DBUS_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered strobe aligned with the RESP state.
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
`ifdef DBUS_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
`ifdef DBUS_TIMEOUT_EN
      wd_q        <= wd_d;
`endif
    end
  end

  assign bus.m_req_ready = req_ready;
  assign bus.s_req_valid = req_valid;
  assign bus.m_rsp_valid = rsp_valid_q;
  assign bus.m_rdata     = rdata_q;
  assign bus.m_rsp_err   = err_q;

  assign bus.s_addr      = bus.m_addr;
  assign bus.s_we        = bus.m_we;
  assign bus.s_wdata     = bus.m_wdata;
  assign bus.s_be        = bus.m_be;

endmodule

// File: tb/tb_dbus_demux3.sv
// Self-checking bench for dbus_demux3: directed cases plus randomized
// transactions checked against a transaction-level reference model.
module tb_dbus_demux3;

`ifdef DBUS_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 8;
`else
  localparam int unsigned TB_TIMEOUT = 255;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dbus_demux3_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dbus_demux3 #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Initiator obligation: payload held while a request is pending.
  a_payload_stable: assert property (@(posedge clk) disable iff (reset)
    (bus.m_req_valid && !bus.m_req_ready) |=>
      $stable({bus.m_addr, bus.m_we, bus.m_wdata, bus.m_be}))
    else $error("payload changed while request pending");

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Address map as plain ranges: 0 = RAM, 1 = IO, 2 = timer, 3 = unmapped.
  function automatic int ref_target(input logic [31:0] a);
    if (a <= 32'h0000_FFFF) return 0;
    if (a >= 32'h1000_0000 && a <= 32'h1000_0FFF) return 1;
    if (a >= 32'h1000_1000 && a <= 32'h1000_10FF) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] edges [8];
    edges = '{32'h0000_FFFF, 32'h0001_0000, 32'h0FFF_FFFF, 32'h1000_0FFF,
              32'h1000_10FF, 32'h1000_1100, 32'h1000_2000, 32'hFFFF_FFFC};
    case ($urandom_range(0, 4))
      0:       return 32'($urandom_range(0, 32'h0000_FFFF));
      1:       return 32'h1000_0000 + 32'($urandom_range(0, 32'h0FFF));
      2:       return 32'h1000_1000 + 32'($urandom_range(0, 32'h00FF));
      3:       return edges[$urandom_range(0, 7)];
      default: return $urandom;
    endcase
  endfunction

  // One complete transaction; every cycle is checked against the model.
  task automatic do_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input logic [3:0] be, input int unsigned rdy_dly,
                        input int unsigned rsp_dly, input logic [31:0] rdata,
                        input logic stray);
    int          tgt;
    int unsigned n_req;
    logic [2:0]  exp_sv;
    tgt    = ref_target(addr);
    exp_sv = (tgt < 3) ? (3'b001 << tgt) : 3'b000;
    n_req  = (tgt < 3) ? rdy_dly : 0;

    for (int unsigned c = 0; c <= n_req; c++) begin
      @(negedge clk);
      bus.m_req_valid = 1'b1;
      bus.m_addr      = addr;
      bus.m_we        = we;
      bus.m_wdata     = wdata;
      bus.m_be        = be;
      bus.s_req_ready = 3'($urandom);
      bus.s_rsp_valid = '0;
      if (tgt < 3) begin
        bus.s_req_ready[tgt] = (c == n_req);
        // A response in the accept cycle itself must be ignored.
        if (stray && c == n_req) begin
          bus.s_rsp_valid[tgt] = 1'b1;
          bus.s_rdata[tgt*32 +: 32] = 32'hBAD0_0000;
        end
      end
      #1;
      check_eq("req_s_req_valid", 32'(bus.s_req_valid), 32'(exp_sv));
      check_eq("req_m_req_ready", 32'(bus.m_req_ready), 32'((tgt == 3) || (c == n_req)));
      check_eq("req_no_rsp", 32'(bus.m_rsp_valid), 32'd0);
    end

    if (tgt < 3) begin
      for (int unsigned k = 1; k <= rsp_dly; k++) begin
        @(negedge clk);
        bus.m_req_valid = 1'b0;
        bus.s_req_ready = '1;
        bus.s_rdata     = {$urandom, $urandom, $urandom};
        bus.s_rsp_valid = stray ? ~exp_sv : 3'b000;
        if (k == rsp_dly) begin
          bus.s_rsp_valid[tgt]      = 1'b1;
          bus.s_rdata[tgt*32 +: 32] = rdata;
        end
        #1;
        check_eq("wait_no_rsp", 32'(bus.m_rsp_valid), 32'd0);
        check_eq("wait_s_req_valid", 32'(bus.s_req_valid), 32'd0);
        check_eq("wait_m_req_ready", 32'(bus.m_req_ready), 32'd0);
      end
    end

    @(negedge clk);
    bus.m_req_valid = 1'b0;
    bus.s_req_ready = '1;
    bus.s_rsp_valid = '1;
    bus.s_rdata     = {$urandom, $urandom, $urandom};
    #1;
    check_eq("rsp_valid", 32'(bus.m_rsp_valid), 32'd1);
    check_eq("rsp_err", 32'(bus.m_rsp_err), 32'(tgt == 3));
    check_eq("rsp_rdata", bus.m_rdata, (tgt == 3 || we) ? 32'd0 : rdata);
    check_eq("rsp_m_req_ready", 32'(bus.m_req_ready), 32'd0);

    @(negedge clk);
    bus.s_req_ready = '0;
    bus.s_rsp_valid = stray ? 3'b111 : 3'b000;
    #1;
    check_eq("rsp_one_cycle", 32'(bus.m_rsp_valid), 32'd0);
    check_eq("idle_s_req_valid", 32'(bus.s_req_valid), 32'd0);

    @(negedge clk);
    bus.s_rsp_valid = '0;
    #1;
    check_eq("idle_rsp_ignored", 32'(bus.m_rsp_valid), 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    bus.m_req_valid = 1'b0;
    bus.m_addr      = '0;
    bus.m_we        = 1'b0;
    bus.m_wdata     = '0;
    bus.m_be        = '0;
    bus.s_req_ready = '0;
    bus.s_rsp_valid = '0;
    bus.s_rdata     = '0;

    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_rsp_valid", 32'(bus.m_rsp_valid), 32'd0);
    check_eq("reset_rdata", bus.m_rdata, 32'd0);
    check_eq("reset_err", 32'(bus.m_rsp_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases.
    do_txn(32'h0000_0040, 1'b0, 32'h0,         4'hF,    0, 2, 32'hDEAD_BEEF, 1'b0);
    do_txn(32'h1000_0004, 1'b1, 32'h0000_00A5, 4'b0001, 3, 1, 32'h5555_5555, 1'b0);
    do_txn(32'h2000_0000, 1'b0, 32'h0,         4'hF,    0, 1, 32'h0,         1'b0);
    do_txn(32'h1000_1008, 1'b0, 32'h0,         4'hF,    0, 3, 32'h0000_0123, 1'b1);

    // Reset while waiting on a target response.
    @(negedge clk);
    bus.m_req_valid = 1'b1;
    bus.m_addr      = 32'h0000_0000;
    bus.m_we        = 1'b0;
    bus.s_req_ready = 3'b001;
    @(negedge clk);
    bus.m_req_valid = 1'b0;
    bus.s_req_ready = '0;
    reset           = 1'b1;
    #1;
    check_eq("rstwait_rdata", bus.m_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus.s_rsp_valid  = 3'b001;
    bus.s_rdata      = {32'h0, 32'h0, 32'hCAFE_F00D};
    @(negedge clk);
    bus.s_rsp_valid = '0;
    #1;
    check_eq("rstwait_rsp_valid", 32'(bus.m_rsp_valid), 32'd0);
    check_eq("rstwait_rdata_late", bus.m_rdata, 32'd0);
    check_eq("rstwait_err", 32'(bus.m_rsp_err), 32'd0);
    @(negedge clk);
    bus.m_req_valid = 1'b1;
    bus.m_addr      = 32'h1000_1000;
    bus.s_req_ready = 3'b000;
    #1;
    check_eq("rstwait_idle_s_req_valid", 32'(bus.s_req_valid), 32'b100);
    check_eq("rstwait_idle_m_req_ready", 32'(bus.m_req_ready), 32'd0);
    @(negedge clk);
    bus.m_req_valid = 1'b0;

`ifdef DBUS_TIMEOUT_EN
    // Watchdog: RAM read with no response, late response ignored.
    @(negedge clk);
    bus.m_req_valid = 1'b1;
    bus.m_addr      = 32'h0000_0100;
    bus.m_we        = 1'b0;
    bus.s_req_ready = 3'b001;
    for (int unsigned k = 1; k <= 11; k++) begin
      @(negedge clk);
      bus.m_req_valid = 1'b0;
      bus.s_req_ready = '0;
      bus.s_rsp_valid = (k == 10) ? 3'b001 : 3'b000;
      bus.s_rdata     = {32'h0, 32'h0, 32'h7777_7777};
      #1;
      check_eq("wd_rsp_valid", 32'(bus.m_rsp_valid), 32'(k == 9));
      if (k == 9) begin
        check_eq("wd_err", 32'(bus.m_rsp_err), 32'd1);
        check_eq("wd_rdata", bus.m_rdata, 32'd0);
      end
    end
    bus.s_rsp_valid = '0;
`endif

    // Randomized transactions.
    for (int n = 0; n < 60; n++) begin
      do_txn(rand_addr(), 1'($urandom), $urandom, 4'($urandom),
             $urandom_range(0, 3), $urandom_range(1, 4), $urandom, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
